// File: rtl/dma_seq_multi_pkg.sv
// Shared types for the multi-channel REU DMA sequencer: transfer types, sequencer
// states and the channel-index width derivation.
package dma_seq_multi_pkg;

    typedef enum logic [1:0] {
        XT_C64_TO_REU = 2'b00,
        XT_REU_TO_C64 = 2'b01,
        XT_SWAP       = 2'b10,
        XT_VERIFY     = 2'b11
    } xferType_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST,
        ST_XFER,
        ST_SWAPWR,
        ST_FLUSH
    } seqState_t;

    // A single channel still needs a 1-bit index.
    function automatic int chWidth(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/dma_seq_multi_if.sv
// Bus, SDRAM-command and descriptor-load signals of the DMA sequencer.
// The master modport is the sequencer side; slave is the host/bus side.
interface dma_seq_multi_if
    import dma_seq_multi_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int CA_W     = 16,
    parameter int REUA_W   = 24,
    parameter int LEN_W    = 16
) ();
    localparam int CH_W = chWidth(CHANNELS);

    logic                BA;
    logic                Equal;
    logic                Ld;
    logic [CH_W-1:0]     LdCh;
    logic [1:0]          LdType;
    logic                LdFixCA;
    logic                LdFixREUA;
    logic [CA_W-1:0]     LdCA;
    logic [REUA_W-1:0]   LdREUA;
    logic [LEN_W-1:0]    LdLen;
    logic [CHANNELS-1:0] Exec;

    logic                DMA;
    logic                nWEDMA;
    logic                RAMRD;
    logic                RAMWR;
    logic [CA_W-1:0]     CA;
    logic [REUA_W-1:0]   REUA;
    logic [CH_W-1:0]     ActCh;
    logic [CHANNELS-1:0] Busy;
    logic [CHANNELS-1:0] Done;
    logic [CHANNELS-1:0] VerifyErr;

    modport master (
        input  BA, Equal, Ld, LdCh, LdType, LdFixCA, LdFixREUA, LdCA, LdREUA, LdLen, Exec,
        output DMA, nWEDMA, RAMRD, RAMWR, CA, REUA, ActCh, Busy, Done, VerifyErr
    );

    modport slave (
        output BA, Equal, Ld, LdCh, LdType, LdFixCA, LdFixREUA, LdCA, LdREUA, LdLen, Exec,
        input  DMA, nWEDMA, RAMRD, RAMWR, CA, REUA, ActCh, Busy, Done, VerifyErr
    );

endinterface

// File: rtl/dma_seq_multi_chan_desc.sv
// One transfer descriptor: type, hold flags, address/length counters.
// With DMASEQ_AUTOLOAD_EN the loaded CA/REUA/length are shadowed and restored at block end.
module dma_chan_desc
    import dma_seq_multi_pkg::*;
#(
    parameter int CA_W   = 16,
    parameter int REUA_W = 24,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              ld,
    input  xferType_t         ldType,
    input  logic              ldFixCA,
    input  logic              ldFixREUA,
    input  logic [CA_W-1:0]   ldCA,
    input  logic [REUA_W-1:0] ldREUA,
    input  logic [LEN_W-1:0]  ldLen,
    input  logic              incCA,
    input  logic              incREUA,
    input  logic              decLen,
`ifdef DMASEQ_AUTOLOAD_EN
    input  logic              restore,
`endif
    output xferType_t         xType,
    output logic [CA_W-1:0]   ca,
    output logic [REUA_W-1:0] reua,
    output logic              lastByte
);
    xferType_t         typeReg;
    logic              fixCAReg;
    logic              fixREUAReg;
    logic [CA_W-1:0]   caReg;
    logic [REUA_W-1:0] reuaReg;
    logic [LEN_W-1:0]  lenReg;

`ifdef DMASEQ_AUTOLOAD_EN
    logic [CA_W-1:0]   caShadowReg;
    logic [REUA_W-1:0] reuaShadowReg;
    logic [LEN_W-1:0]  lenShadowReg;

    always_ff @(negedge clk or negedge rstN) begin
        if (!rstN) begin
            caShadowReg   <= '0;
            reuaShadowReg <= '0;
            lenShadowReg  <= '0;
        end else if (ld) begin
            caShadowReg   <= ldCA;
            reuaShadowReg <= ldREUA;
            lenShadowReg  <= ldLen;
        end
    end
`endif

    // Length 0 wraps to all-ones on the first decrement, giving 2^LEN_W bytes.
    always_ff @(negedge clk or negedge rstN) begin
        if (!rstN) begin
            typeReg    <= XT_C64_TO_REU;
            fixCAReg   <= 1'b0;
            fixREUAReg <= 1'b0;
            caReg      <= '0;
            reuaReg    <= '0;
            lenReg     <= '0;
        end else if (ld) begin
            typeReg    <= ldType;
            fixCAReg   <= ldFixCA;
            fixREUAReg <= ldFixREUA;
            caReg      <= ldCA;
            reuaReg    <= ldREUA;
            lenReg     <= ldLen;
`ifdef DMASEQ_AUTOLOAD_EN
        end else if (restore) begin
            caReg      <= caShadowReg;
            reuaReg    <= reuaShadowReg;
            lenReg     <= lenShadowReg;
`endif
        end else begin
            if (incCA && !fixCAReg) begin
                caReg <= caReg + CA_W'(1);
            end
            if (incREUA && !fixREUAReg) begin
                reuaReg <= reuaReg + REUA_W'(1);
            end
            if (decLen) begin
                lenReg <= lenReg - LEN_W'(1);
            end
        end
    end

    assign xType    = typeReg;
    assign ca       = caReg;
    assign reua     = reuaReg;
    assign lastByte = (lenReg == LEN_W'(1));

endmodule

// File: rtl/dma_seq_multi.sv
// Multi-channel REU DMA sequencer: round-robin arbiter plus transfer FSM, state on PHI2 falling edge.
// Optional DMASEQ_AUTOLOAD_EN restores each channel's loaded descriptor at block end.
module dma_seq_multi
    import dma_seq_multi_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int CA_W     = 16,
    parameter int REUA_W   = 24,
    parameter int LEN_W    = 16
) (
    input  logic            PHI2,
    input  logic            nRESET,
    dma_seq_multi_if.master bus
);
    localparam int CH_W = chWidth(CHANNELS);

    seqState_t           stateReg, stateNext;
    logic [CH_W-1:0]     actChReg, grantCh;
    logic [CHANNELS-1:0] busyReg, doneReg, verifyErrReg;
    logic [CHANNELS-1:0] pending, ldAccept, chLast;
    logic                anyPending, grant;
    logic                incCA, incREUA, decLen, blockEnd, setErr;
    logic                dmaOut, nWeOut, ramRdOut, ramWrOut;

    xferType_t           chType [CHANNELS];
    logic [CA_W-1:0]     chCA   [CHANNELS];
    logic [REUA_W-1:0]   chREUA [CHANNELS];

    xferType_t           curType;
    logic [CA_W-1:0]     curCA;
    logic [REUA_W-1:0]   curREUA;
    logic                curLast;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic chSel;
        assign chSel = (actChReg == CH_W'(gi));
        // The running channel's descriptor is frozen until the block ends.
        assign ldAccept[gi] = bus.Ld && (bus.LdCh == CH_W'(gi)) &&
                              !(chSel && (stateReg != ST_IDLE));

        dma_chan_desc #(
            .CA_W   (CA_W),
            .REUA_W (REUA_W),
            .LEN_W  (LEN_W)
        ) u_desc (
            .clk       (PHI2),
            .rstN      (nRESET),
            .ld        (ldAccept[gi]),
            .ldType    (xferType_t'(bus.LdType)),
            .ldFixCA   (bus.LdFixCA),
            .ldFixREUA (bus.LdFixREUA),
            .ldCA      (bus.LdCA),
            .ldREUA    (bus.LdREUA),
            .ldLen     (bus.LdLen),
            .incCA     (incCA && chSel),
            .incREUA   (incREUA && chSel),
            .decLen    (decLen && chSel),
`ifdef DMASEQ_AUTOLOAD_EN
            .restore   (blockEnd && chSel),
`endif
            .xType     (chType[gi]),
            .ca        (chCA[gi]),
            .reua      (chREUA[gi]),
            .lastByte  (chLast[gi])
        );
    end

    always_comb begin
        curType = XT_C64_TO_REU;
        curCA   = '0;
        curREUA = '0;
        curLast = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (actChReg == CH_W'(i)) begin
                curType = chType[i];
                curCA   = chCA[i];
                curREUA = chREUA[i];
                curLast = chLast[i];
            end
        end
    end

    // Round-robin: search starts one past the last-served channel (actChReg).
    assign pending = bus.Exec & ~busyReg;

    always_comb begin
        int idx;
        idx        = 0;
        anyPending = 1'b0;
        grantCh    = actChReg;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = (int'(actChReg) + i) % CHANNELS;
            if (!anyPending && pending[idx]) begin
                anyPending = 1'b1;
                grantCh    = CH_W'(idx);
            end
        end
    end

    always_comb begin
        stateNext = stateReg;
        grant     = 1'b0;
        dmaOut    = 1'b0;
        nWeOut    = 1'b0;
        ramRdOut  = 1'b0;
        ramWrOut  = 1'b0;
        incCA     = 1'b0;
        incREUA   = 1'b0;
        decLen    = 1'b0;
        blockEnd  = 1'b0;
        setErr    = 1'b0;
        case (stateReg)
            ST_IDLE: begin
                if (anyPending) begin
                    grant     = 1'b1;
                    stateNext = ST_FIRST;
                end
            end
            ST_FIRST, ST_XFER: begin
                dmaOut   = 1'b1;
                nWeOut   = (curType != XT_REU_TO_C64);
                ramRdOut = bus.BA && (curType != XT_C64_TO_REU);
                // C64->REU writes the byte fetched in the previous cycle.
                ramWrOut = bus.BA && (curType == XT_C64_TO_REU) && (stateReg == ST_XFER);
                if (bus.BA) begin
                    if (curType == XT_SWAP) begin
                        stateNext = ST_SWAPWR;
                    end else if ((curType == XT_VERIFY) && !bus.Equal) begin
                        setErr    = 1'b1;
                        blockEnd  = 1'b1;
                        stateNext = ST_IDLE;
                    end else begin
                        incCA   = 1'b1;
                        decLen  = 1'b1;
                        incREUA = (curType != XT_C64_TO_REU) || (stateReg == ST_XFER);
                        if (!curLast) begin
                            stateNext = ST_XFER;
                        end else if (curType == XT_C64_TO_REU) begin
                            stateNext = ST_FLUSH;
                        end else begin
                            blockEnd  = 1'b1;
                            stateNext = ST_IDLE;
                        end
                    end
                end
            end
            ST_SWAPWR: begin
                dmaOut   = 1'b1;
                ramWrOut = bus.BA;
                if (bus.BA) begin
                    incCA   = 1'b1;
                    incREUA = 1'b1;
                    decLen  = 1'b1;
                    if (curLast) begin
                        blockEnd  = 1'b1;
                        stateNext = ST_IDLE;
                    end else begin
                        stateNext = ST_XFER;
                    end
                end
            end
            ST_FLUSH: begin
                ramWrOut  = 1'b1;
                incREUA   = 1'b1;
                blockEnd  = 1'b1;
                stateNext = ST_IDLE;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge PHI2 or negedge nRESET) begin
        if (!nRESET) begin
            stateReg     <= ST_IDLE;
            actChReg     <= '0;
            busyReg      <= '0;
            doneReg      <= '0;
            verifyErrReg <= '0;
        end else begin
            stateReg <= stateNext;
            doneReg  <= '0;
            if (grant) begin
                actChReg <= grantCh;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (grant && (grantCh == CH_W'(i))) begin
                    busyReg[i] <= 1'b1;
                end
                if (blockEnd && (actChReg == CH_W'(i))) begin
                    busyReg[i] <= 1'b0;
                    doneReg[i] <= 1'b1;
                end
                if (ldAccept[i]) begin
                    verifyErrReg[i] <= 1'b0;
                end else if (setErr && (actChReg == CH_W'(i))) begin
                    verifyErrReg[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.DMA       = dmaOut;
    assign bus.nWEDMA    = nWeOut;
    assign bus.RAMRD     = ramRdOut;
    assign bus.RAMWR     = ramWrOut;
    assign bus.CA        = curCA;
    assign bus.REUA      = curREUA;
    assign bus.ActCh     = actChReg;
    assign bus.Busy      = busyReg;
    assign bus.Done      = doneReg;
    assign bus.VerifyErr = verifyErrReg;

endmodule

// File: tb/tb_dma_seq_multi.sv
// Directed bench for dma_seq_multi: inputs change just after the PHI2 falling edge,
// outputs are checked on the rising edge. Expectations follow DMASEQ_AUTOLOAD_EN.
module tb_dma_seq_multi;
    import dma_seq_multi_pkg::*;

    localparam int CHANNELS = 2;
    localparam int CA_W     = 16;
    localparam int REUA_W   = 24;
    localparam int LEN_W    = 16;
    localparam int CH_W     = chWidth(CHANNELS);
`ifdef DMASEQ_AUTOLOAD_EN
    localparam bit AUTOLOAD = 1'b1;
`else
    localparam bit AUTOLOAD = 1'b0;
`endif

    logic PHI2 = 1'b0;
    logic nRESET;
    int   errCount   = 0;
    int   checkCount = 0;
    bit   countEn    = 1'b0;
    int   ramCmdCycles = 0;
    int   dmaCycles    = 0;

    dma_seq_multi_if #(
        .CHANNELS (CHANNELS), .CA_W (CA_W), .REUA_W (REUA_W), .LEN_W (LEN_W)
    ) bus ();

    dma_seq_multi #(
        .CHANNELS (CHANNELS), .CA_W (CA_W), .REUA_W (REUA_W), .LEN_W (LEN_W)
    ) dut (
        .PHI2   (PHI2),
        .nRESET (nRESET),
        .bus    (bus)
    );

    always #5 PHI2 = ~PHI2;

    always @(posedge PHI2) begin
        if (countEn) begin
            if (bus.RAMRD || bus.RAMWR) ramCmdCycles++;
            if (bus.DMA) dmaCycles++;
        end
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic nextCycle();
        @(negedge PHI2);
        #1;
    endtask

    task automatic midCycle();
        @(posedge PHI2);
    endtask

    task automatic setDesc(input int ch, input logic [1:0] t, input logic fixCa, input logic fixReua,
                           input logic [CA_W-1:0] ca, input logic [REUA_W-1:0] reua,
                           input logic [LEN_W-1:0] len);
        bus.Ld        = 1'b1;
        bus.LdCh      = CH_W'(ch);
        bus.LdType    = t;
        bus.LdFixCA   = fixCa;
        bus.LdFixREUA = fixReua;
        bus.LdCA      = ca;
        bus.LdREUA    = reua;
        bus.LdLen     = len;
    endtask

    task automatic loadDesc(input int ch, input logic [1:0] t, input logic fixCa, input logic fixReua,
                            input logic [CA_W-1:0] ca, input logic [REUA_W-1:0] reua,
                            input logic [LEN_W-1:0] len);
        setDesc(ch, t, fixCa, fixReua, ca, reua, len);
        nextCycle();
        bus.Ld = 1'b0;
    endtask

    initial begin
        nRESET = 1'b1;
        bus.BA = 1'b0; bus.Equal = 1'b1; bus.Ld = 1'b0; bus.LdCh = '0; bus.LdType = '0;
        bus.LdFixCA = 1'b0; bus.LdFixREUA = 1'b0; bus.LdCA = '0; bus.LdREUA = '0;
        bus.LdLen = '0; bus.Exec = '0;
        #1 nRESET = 1'b0;
        #2;
        checkEq("reset DMA", 32'(bus.DMA), 32'h0);
        checkEq("reset Busy", 32'(bus.Busy), 32'h0);
        checkEq("reset ActCh", 32'(bus.ActCh), 32'h0);
        checkEq("reset CA", 32'(bus.CA), 32'h0);
        nextCycle();
        nextCycle();
        nRESET = 1'b1;
        bus.BA = 1'b1;

        // C64->REU on ch0, three bytes
        loadDesc(0, 2'b00, 1'b0, 1'b0, 16'h1000, 24'h000010, 16'd3);
        bus.Exec = 2'b01;
        midCycle();
        checkEq("c2r idle DMA", 32'(bus.DMA), 32'h0);
        nextCycle(); bus.Exec = 2'b00;
        midCycle();
        checkEq("c2r c1 DMA", 32'(bus.DMA), 32'h1);
        checkEq("c2r c1 nWEDMA", 32'(bus.nWEDMA), 32'h1);
        checkEq("c2r c1 RAMWR", 32'(bus.RAMWR), 32'h0);
        checkEq("c2r c1 CA", 32'(bus.CA), 32'h1000);
        checkEq("c2r c1 Busy", 32'(bus.Busy), 32'h1);
        nextCycle(); midCycle();
        checkEq("c2r c2 RAMWR", 32'(bus.RAMWR), 32'h1);
        checkEq("c2r c2 CA", 32'(bus.CA), 32'h1001);
        checkEq("c2r c2 REUA", 32'(bus.REUA), 32'h10);
        nextCycle(); midCycle();
        checkEq("c2r c3 RAMWR", 32'(bus.RAMWR), 32'h1);
        checkEq("c2r c3 REUA", 32'(bus.REUA), 32'h11);
        nextCycle(); midCycle();
        checkEq("c2r flush DMA", 32'(bus.DMA), 32'h0);
        checkEq("c2r flush RAMWR", 32'(bus.RAMWR), 32'h1);
        checkEq("c2r flush REUA", 32'(bus.REUA), 32'h12);
        checkEq("c2r flush Done", 32'(bus.Done), 32'h0);
        nextCycle(); midCycle();
        checkEq("c2r end Done", 32'(bus.Done), 32'h1);
        checkEq("c2r end Busy", 32'(bus.Busy), 32'h0);
        checkEq("c2r end RAMWR", 32'(bus.RAMWR), 32'h0);
        checkEq("c2r end CA", 32'(bus.CA), AUTOLOAD ? 32'h1000 : 32'h1003);
        checkEq("c2r end REUA", 32'(bus.REUA), AUTOLOAD ? 32'h10 : 32'h13);
        nextCycle(); midCycle();
        checkEq("c2r Done once", 32'(bus.Done), 32'h0);

        // Swap on ch1 with a two-cycle BA stall
        loadDesc(1, 2'b10, 1'b0, 1'b0, 16'h2000, 24'h000100, 16'd2);
        bus.Exec = 2'b10;
        midCycle();
        nextCycle(); bus.Exec = 2'b00; countEn = 1'b1;
        midCycle();
        checkEq("swap rd ActCh", 32'(bus.ActCh), 32'h1);
        checkEq("swap rd RAMRD", 32'(bus.RAMRD), 32'h1);
        checkEq("swap rd nWEDMA", 32'(bus.nWEDMA), 32'h1);
        checkEq("swap rd CA", 32'(bus.CA), 32'h2000);
        nextCycle(); midCycle();
        checkEq("swap wr RAMWR", 32'(bus.RAMWR), 32'h1);
        checkEq("swap wr RAMRD", 32'(bus.RAMRD), 32'h0);
        checkEq("swap wr nWEDMA", 32'(bus.nWEDMA), 32'h0);
        nextCycle(); bus.BA = 1'b0;
        midCycle();
        checkEq("swap stall DMA", 32'(bus.DMA), 32'h1);
        checkEq("swap stall RAMRD", 32'(bus.RAMRD), 32'h0);
        checkEq("swap stall nWEDMA", 32'(bus.nWEDMA), 32'h1);
        checkEq("swap stall CA", 32'(bus.CA), 32'h2001);
        nextCycle(); midCycle();
        checkEq("swap stall2 RAMWR", 32'(bus.RAMWR), 32'h0);
        nextCycle(); bus.BA = 1'b1;
        midCycle();
        checkEq("swap rd2 RAMRD", 32'(bus.RAMRD), 32'h1);
        nextCycle(); midCycle();
        checkEq("swap wr2 RAMWR", 32'(bus.RAMWR), 32'h1);
        checkEq("swap wr2 CA", 32'(bus.CA), 32'h2001);
        nextCycle(); countEn = 1'b0;
        midCycle();
        checkEq("swap end DMA", 32'(bus.DMA), 32'h0);
        checkEq("swap end Done", 32'(bus.Done), 32'h2);
        checkEq("swap end CA", 32'(bus.CA), AUTOLOAD ? 32'h2000 : 32'h2002);
        checkEq("swap end REUA", 32'(bus.REUA), AUTOLOAD ? 32'h100 : 32'h102);
        checkEq("swap RAM cmd cycles", 32'(ramCmdCycles), 32'd4);
        checkEq("swap DMA cycles", 32'(dmaCycles), 32'd6);

        // Verify on ch0 with a mismatch on byte 2 of 5
        loadDesc(0, 2'b11, 1'b0, 1'b0, 16'h3000, 24'h000200, 16'd5);
        bus.Exec = 2'b01;
        midCycle();
        nextCycle(); bus.Exec = 2'b00;
        midCycle();
        checkEq("ver c1 RAMRD", 32'(bus.RAMRD), 32'h1);
        checkEq("ver c1 ActCh", 32'(bus.ActCh), 32'h0);
        nextCycle(); bus.Equal = 1'b0;
        midCycle();
        checkEq("ver c2 CA", 32'(bus.CA), 32'h3001);
        checkEq("ver c2 VerifyErr", 32'(bus.VerifyErr), 32'h0);
        nextCycle(); bus.Equal = 1'b1;
        midCycle();
        checkEq("ver end DMA", 32'(bus.DMA), 32'h0);
        checkEq("ver end VerifyErr", 32'(bus.VerifyErr), 32'h1);
        checkEq("ver end Done", 32'(bus.Done), 32'h1);
        checkEq("ver end CA", 32'(bus.CA), AUTOLOAD ? 32'h3000 : 32'h3001);
        checkEq("ver end REUA", 32'(bus.REUA), AUTOLOAD ? 32'h200 : 32'h201);

        // Round-robin: both held, last served ch0 -> ch1 then ch0
        loadDesc(0, 2'b01, 1'b0, 1'b0, 16'h4000, 24'h000400, 16'd1);
        midCycle();
        checkEq("ld clears VerifyErr", 32'(bus.VerifyErr), 32'h0);
        loadDesc(1, 2'b01, 1'b0, 1'b0, 16'h5000, 24'h000500, 16'd1);
        bus.Exec = 2'b11;
        midCycle();
        nextCycle(); midCycle();
        checkEq("rr first ActCh", 32'(bus.ActCh), 32'h1);
        checkEq("rr first CA", 32'(bus.CA), 32'h5000);
        checkEq("rr first nWEDMA", 32'(bus.nWEDMA), 32'h0);
        checkEq("rr first RAMRD", 32'(bus.RAMRD), 32'h1);
        nextCycle(); midCycle();
        checkEq("rr first Done", 32'(bus.Done), 32'h2);
        nextCycle(); bus.Exec = 2'b00;
        midCycle();
        checkEq("rr second ActCh", 32'(bus.ActCh), 32'h0);
        checkEq("rr second CA", 32'(bus.CA), 32'h4000);
        nextCycle(); midCycle();
        checkEq("rr second Done", 32'(bus.Done), 32'h1);

        // REU->C64 with held REUA and CA wrap
        loadDesc(1, 2'b01, 1'b0, 1'b1, 16'hFFFF, 24'hFFFFFF, 16'd2);
        bus.Exec = 2'b10;
        midCycle();
        nextCycle(); bus.Exec = 2'b00;
        midCycle();
        checkEq("wrap c1 CA", 32'(bus.CA), 32'hFFFF);
        checkEq("wrap c1 REUA", 32'(bus.REUA), 32'hFFFFFF);
        nextCycle(); midCycle();
        checkEq("wrap c2 CA", 32'(bus.CA), 32'h0000);
        checkEq("wrap c2 REUA", 32'(bus.REUA), 32'hFFFFFF);
        nextCycle(); midCycle();
        checkEq("wrap end Done", 32'(bus.Done), 32'h2);
        checkEq("wrap end CA", 32'(bus.CA), AUTOLOAD ? 32'hFFFF : 32'h0001);
        checkEq("wrap end REUA", 32'(bus.REUA), 32'hFFFFFF);

        // Asynchronous reset in the middle of a C64->REU block
        loadDesc(0, 2'b00, 1'b0, 1'b0, 16'h6000, 24'h000300, 16'd4);
        bus.Exec = 2'b01;
        midCycle();
        nextCycle(); bus.Exec = 2'b00;
        nextCycle(); midCycle();
        checkEq("rst pre RAMWR", 32'(bus.RAMWR), 32'h1);
        #2 nRESET = 1'b0;
        #1;
        checkEq("rst async DMA", 32'(bus.DMA), 32'h0);
        checkEq("rst async RAMWR", 32'(bus.RAMWR), 32'h0);
        checkEq("rst async nWEDMA", 32'(bus.nWEDMA), 32'h0);
        checkEq("rst async Busy", 32'(bus.Busy), 32'h0);
        checkEq("rst async CA", 32'(bus.CA), 32'h0);
        nextCycle(); midCycle();
        checkEq("rst hold Done", 32'(bus.Done), 32'h0);
        nextCycle(); nRESET = 1'b1;
        midCycle();
        checkEq("rst after Done", 32'(bus.Done), 32'h0);
        checkEq("rst after RAMWR", 32'(bus.RAMWR), 32'h0);

        // Load and grant on the same edge; a load to the active channel is ignored
        bus.Exec = 2'b10;
        loadDesc(1, 2'b01, 1'b0, 1'b0, 16'h7000, 24'h000700, 16'd1);
        bus.Exec = 2'b00;
        setDesc(1, 2'b01, 1'b0, 1'b0, 16'h7777, 24'h000777, 16'd9);
        midCycle();
        checkEq("ldgrant CA", 32'(bus.CA), 32'h7000);
        checkEq("ldgrant DMA", 32'(bus.DMA), 32'h1);
        nextCycle(); bus.Ld = 1'b0;
        midCycle();
        checkEq("ldgrant Done", 32'(bus.Done), 32'h2);
        checkEq("ld ignored CA", 32'(bus.CA), AUTOLOAD ? 32'h7000 : 32'h7001);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dma_seq_multi.md
DMA_SEQ_MULTI -- requirements
Module: dma_seq_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, meaning number of independent transfer descriptors (1..4).
REQ-002 SHALL have parameter CA_W, default 16, meaning C64 address width.
REQ-003 SHALL have parameter REUA_W, default 24, meaning REU address width.
REQ-004 SHALL have parameter LEN_W, default 16, meaning transfer length width.
REQ-005 SHALL have ports:
- PHI2  in  1  clock; all state updates on falling edge.
- nRESET  in  1  asynchronous, active-low reset.
- BA  in  1  C64 bus available.
- Equal  in  1  REU read data equals C64 bus data.
- Ld  in  1  descriptor load strobe.
- LdCh  in  CH_W  descriptor index, CH_W = max(1, clog2(CHANNELS)).
- LdType  in  2  transfer type: 00 C64->REU, 01 REU->C64, 10 swap, 11 verify.
- LdFixCA, LdFixREUA  in  1 each  hold C64 address / hold REU address.
- LdCA  in  CA_W;  LdREUA  in  REUA_W;  LdLen  in  LEN_W  descriptor values.
- Exec  in  CHANNELS  per-channel start request; level-sensitive.
- DMA, nWEDMA, RAMRD, RAMWR  out  1 each  bus and SDRAM commands.
- CA  out  CA_W;  REUA  out  REUA_W  addresses of the active channel.
- ActCh  out  CH_W  active channel index.
- Busy, Done, VerifyErr  out  CHANNELS each  running; one-cycle end pulse; sticky mismatch flag.

Function
REQ-006 SHALL implement states IDLE, FIRST, XFER, SWAPWR, FLUSH.
REQ-007 IDLE SHALL grant pending Exec round-robin, starting after the last-served channel, and SHALL go to FIRST with DMA=1.
REQ-008 Channel ownership SHALL change only in IDLE. A block SHALL never be preempted.
REQ-009 Per type, SHALL drive FIRST and XFER commands as follows:
- C64->REU: nWEDMA=1; RAMWR asserted from XFER onward, one cycle behind each C64 read.
- REU->C64: nWEDMA=0, RAMRD=1.
- Swap: read cycle nWEDMA=1/RAMRD=1, then SWAPWR nWEDMA=0/RAMWR=1, alternating.
- Verify: nWEDMA=1, RAMRD=1.
REQ-010 While BA=0 in FIRST/XFER/SWAPWR, the block SHALL hold state, counters and nWEDMA, and SHALL force RAMRD=RAMWR=0.
REQ-011 Each completed byte (BA=1) SHALL:
- increment CA unless FixCA is set;
- increment REUA unless FixREUA is set (C64->REU one cycle delayed);
- decrement length. Swap counts a byte at SWAPWR only.
REQ-012 CA SHALL wrap modulo 2^CA_W and REUA modulo 2^REUA_W.
REQ-013 A loaded length of 0 SHALL mean 2^LEN_W bytes.
REQ-014 When the final byte completes, the block SHALL end with DMA=0 next cycle. C64->REU SHALL first pass through FLUSH, with RAMWR=1 and DMA=0, for one cycle.
REQ-015 In verify, when Equal=0 is sampled during a completed read, the block SHALL:
- set VerifyErr[ch];
- suppress that cycle's increments;
- end the block next cycle.
REQ-016 Done[ch] SHALL pulse for one cycle on return to IDLE, and Busy[ch] SHALL clear on that same cycle.
REQ-017 Ld SHALL write the descriptor and clear VerifyErr[LdCh]. Ld SHALL be ignored when LdCh is the active channel.
REQ-018 When Ld and a grant to the same channel occur on the same edge, the grant SHALL use the newly loaded values.
REQ-019 Exec for a channel already Busy SHALL have no effect.

Reset
REQ-020 nRESET low SHALL immediately, without waiting for a clock:
- set state IDLE;
- drive DMA=nWEDMA=RAMRD=RAMWR=0;
- clear all descriptors, Busy, Done, VerifyErr and ActCh;
- set the round-robin pointer to channel 0.
REQ-021 Reset mid-transfer SHALL abort it with no Done pulse and no FLUSH write.

Configuration
REQ-022 With DMASEQ_AUTOLOAD_EN defined, each channel SHALL keep a shadow copy of CA, REUA and length, restored at every block end, including verify abort.
REQ-023 Without DMASEQ_AUTOLOAD_EN, there SHALL be no shadow registers, and counters SHALL retain their final values after a block.

Structure
REQ-024 A shared package SHALL hold the transfer-type enum, the state enum and the CH_W derivation.
REQ-025 Per-channel descriptor storage and counting SHALL be one sub-module, dma_chan_desc, instantiated CHANNELS times. The sequencer and arbiter SHALL remain in dma_seq_multi.

Verification
REQ-026 The bench SHALL cover:
- C64->REU on ch0, CA=0x1000, REUA=0x000010, Len=3, BA=1 -> three read cycles, RAMWR on cycles 2-4 with FLUSH last; final CA=0x1003, REUA=0x000013; Done[0] one pulse.
- Swap on ch1, Len=2, BA low for 2 cycles mid-block -> RAMRD/RAMWR alternate, stall cycles show no RAM command; 4 active cycles total.
- Verify with Equal=0 on byte 2 of Len=5 -> VerifyErr[ch] set; CA advanced by 1; DMA drops next cycle.
- Exec[0] and Exec[1] held together, last-served channel 0 -> ch1 runs first, ch0 next.
- REU->C64 with FixREUA=1, REUA=0xFFFFFF, CA=0xFFFF, Len=2 -> CA wraps to 0x0001; REUA constant.
- nRESET low mid-block -> outputs 0 asynchronously; no Done; with DMASEQ_AUTOLOAD_EN, a completed block restores loaded CA/REUA/Len.
